apc_accum: RTL

- Sequential successor to the fixed 32-input combinational approximate parallel counter.
- Each accepted beat, it counts the ones in an N_IN-bit stochastic bitstream slice, using either an exact or an approximate (APC) count.
- It accumulates the per-beat counts over a window of WIN_LEN beats and presents the window total through a valid/ready handshake.
- It sits between the stochastic-number generators and the binary back-end of stochastic neuron datapaths.

---
 rtl/apc_pkg.sv | 25 ++
 rtl/apc_popcount.sv | 36 +++
 rtl/apc_accum.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/apc_pkg.sv
// Shared definitions for the approximate parallel counter family:
// count-mode constants, the window state encoding and width helpers.
package apc_pkg;

  localparam int APC_EXACT  = 0;
  localparam int APC_APPROX = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DONE
  } apc_state_t;

  // Per-beat count width: enough to hold N_IN itself.
  function automatic int apc_cnt_width(input int n_in);
    return $clog2(n_in) + 1;
  endfunction

  // Window total width: holds N_IN*WIN_LEN, with a spare bit for the bipolar form.
  function automatic int apc_acc_width(input int n_in, input int win_len);
    return apc_cnt_width(n_in) + $clog2(win_len) + 1;
  endfunction

endpackage

// File: rtl/apc_popcount.sv
// Combinational per-beat counter. MODE selects an exact popcount or the
// approximate pair count (OR on even pairs, AND on odd pairs, doubled).
module apc_popcount
  import apc_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int MODE  = APC_APPROX,
  parameter int CNT_W = apc_cnt_width(N_IN)
) (
  input  logic [N_IN-1:0]  data,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] pair_sum;

  // Sum either every bit or one approximate vote per bit pair.
  always_comb begin
    pair_sum = '0;
    count    = '0;
    if (MODE == APC_EXACT) begin
      for (int i = 0; i < N_IN; i++) begin
        count = count + CNT_W'(data[i]);
      end
    end else begin
      for (int p = 0; p < N_IN / 2; p++) begin
        if ((p % 2) == 0) begin
          pair_sum = pair_sum + CNT_W'(data[2*p+1] | data[2*p]);
        end else begin
          pair_sum = pair_sum + CNT_W'(data[2*p+1] & data[2*p]);
        end
      end
      count = {pair_sum[CNT_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/apc_accum.sv
// Windowed accumulator around apc_popcount: counts each accepted beat,
// sums WIN_LEN beats and offers the total on a valid/ready output.
// Optional build macro APC_BIPOLAR_EN turns out_sum into the signed
// bipolar value 2*total - N_IN*WIN_LEN.
module apc_accum
  import apc_pkg::*;
#(
  parameter int N_IN    = 32,
  parameter int WIN_LEN = 256,
  parameter int MODE    = APC_APPROX,
  parameter int CNT_W   = apc_cnt_width(N_IN),
  parameter int ACC_W   = apc_acc_width(N_IN, WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             cont,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  localparam int BEAT_W = $clog2(WIN_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WIN_LEN - 1);

  apc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             vld_q;
  logic [ACC_W-1:0] acc_q;
  logic [BEAT_W-1:0] beat_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             ready, accept, win_start, finish, handshake;
  logic [ACC_W-1:0] total, result;

  apc_popcount #(
    .N_IN  (N_IN),
    .MODE  (MODE),
    .CNT_W (CNT_W)
  ) u_popcount (
    .data  (in_bits),
    .count (cnt_d)
  );

  assign total = acc_q + ACC_W'(cnt_q);

`ifdef APC_BIPOLAR_EN
  localparam logic [ACC_W-1:0] FULL_SCALE = ACC_W'(N_IN * WIN_LEN);
  assign result = {total[ACC_W-2:0], 1'b0} - FULL_SCALE;
`else
  assign result = total;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    accept    = 1'b0;
    win_start = 1'b0;
    finish    = 1'b0;
    handshake = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = ACCUM;
            win_start = 1'b1;
          end
        end
        ACCUM: begin
          ready  = 1'b1;
          accept = in_valid;
          if (in_valid && (beat_q == LAST_BEAT)) state_d = FLUSH;
        end
        FLUSH: begin
          finish  = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            handshake = 1'b1;
            if (cont) begin
              state_d   = ACCUM;
              win_start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Count pipeline, accumulator, beat counter and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      vld_q       <= 1'b0;
      acc_q       <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else if (clear) begin
      vld_q       <= 1'b0;
      acc_q       <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        cnt_q  <= cnt_d;
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end
      if (win_start) begin
        acc_q  <= '0;
        beat_q <= '0;
        vld_q  <= 1'b0;
      end else if (vld_q) begin
        acc_q <= total;
      end
      if (finish) begin
        out_sum_q   <= result;
        out_valid_q <= 1'b1;
      end
      if (handshake) out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign busy      = (state_q != IDLE);

endmodule
